freq_gate_counter: RTL and testbench
====================================

# freq_gate_counter

Gated pulse counter directly upstream of the 4-digit LED display controller. It counts rising edges of an asynchronous input over a fixed gate window and latches the result onto the 14-bit `num` bus the display consumes. The result is clamped to the 4-digit decimal range, with an overflow flag. The new value is published once per window, so the display sees a stable number between updates.

## Interface
Parameters:
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles; legal range ≥ 2.
- `MAX_COUNT`, default 9999: largest displayable value; must be < 2^14 − 1.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sig_in`  in  1: asynchronous pulse input to be counted.
- `num`  out  14: latched count of the last completed window; drives the display `num` input.
- `valid`  out  1: one-cycle strobe, high in the cycle `num` takes a new value.
- `ovf`  out  1: high when the last completed window had more than `MAX_COUNT` edges.

## Operation
- Input path: `sig_in` → 2-flop synchronizer → delay flop. `edge` = sync2 & ~dly (rising edge only).
- Gate counter `gcnt`:
  - Counts 0 … `GATE_CYCLES`−1, then wraps to 0.
  - `gate_end` = (`gcnt` == `GATE_CYCLES`−1).
- Edge counter `ecnt` (14 bit):
  - Increments on `edge`.
  - Saturates at `MAX_COUNT`+1 and never wraps.
- On `gate_end`:
  - `total` = `ecnt` + `edge`, saturated at `MAX_COUNT`+1. An edge in the terminal cycle belongs to the closing window.
  - `num` ← min(`total`, `MAX_COUNT`).
  - `ovf` ← (`total` > `MAX_COUNT`).
  - `valid` ← 1.
  - `ecnt` ← 0.
- Otherwise `valid` ← 0, and `num`/`ovf` hold their values.
- States: implicit two-phase behaviour (COUNTING, LATCH on `gate_end`). No separate FSM register is required.

## Timing
- Reset values:
  - `num`=0, `valid`=0, `ovf`=0.
  - `gcnt`=0, `ecnt`=0.
  - sync1/sync2/dly=0.
- Reset consequence: if `sig_in` is high across reset release, it registers as one edge in the first window.
- Reset mid-window discards the partial count. The first `valid` follows exactly `GATE_CYCLES` cycles after the cycle `rst` is sampled low.
- Input latency: a `sig_in` rise becomes an `edge` 2–3 cycles later, depending on phase against `clk`.
- Output latency: `num`, `ovf` and `valid` update on the clock edge that ends cycle `GATE_CYCLES`−1 of a window. `valid` is high for exactly 1 cycle per window.
- Back-to-back windows: the first cycle after `gate_end` is cycle 0 of the next window. No edges are lost or double-counted.
- Edge rate: at most one edge per 2 cycles, so the maximum count is `GATE_CYCLES`/2.

## Configuration
- `FREQ_HOLD_EN`:
  - When defined: adds input port `hold` (1 bit). While `hold`=1, `num` and `ovf` freeze and `valid` stays 0, but windows keep running and counting. The first `gate_end` with `hold`=0 publishes that window's count.
  - When undefined: no `hold` port; every window publishes.

## Structure
- Package `freq_pkg`: `NUM_W`=14, default `MAX_COUNT`=9999, typedef `num_t` (logic [`NUM_W`−1:0]).
- Sub-module `sig_sync_edge`: 2-flop synchronizer plus rising-edge detector, with synchronous reset. Ports: `clk`, `rst`, `d`, `edge`.

## Test plan
- `GATE_CYCLES`=100, `sig_in` square wave of period 10 cycles → every window after the first: `num`=10, `ovf`=0, `valid` high 1 cycle every 100 cycles.
- `GATE_CYCLES`=20000, `sig_in` toggles every cycle (edge every 2 cycles) → `num`=9999, `ovf`=1. Drop to period 4 → next full window `num`=5000, `ovf`=0.
- `sig_in` held low → `num`=0, `ovf`=0, `valid` still strobes every `GATE_CYCLES`.
- Edge aligned so `edge`=1 exactly in cycle `GATE_CYCLES`−1 → that edge counted in the closing window and absent from the next window.
- Assert `rst` for 3 cycles mid-window after `num`=10 → `num`=0, `valid`=0, `ovf`=0 during and after reset. Next `valid` arrives exactly `GATE_CYCLES` cycles after release.
- `FREQ_HOLD_EN` build: `hold`=1 across two windows with period-10 input, after `num`=10 and then switching to period 20 → `num` stays 10, no `valid`. Release `hold` → next `gate_end` gives `num`=5.

Source files
------------

// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : freq_pkg
//  Purpose  : Shared widths, defaults and helpers for the gated pulse counter
//             that feeds the 4-digit LED display controller.
//  Contents : NUM_W         - width of the display number bus
//             DEF_MAX_COUNT - default largest displayable value
//             num_t         - display number / edge count type
//             sat_add_bit   - add a single bit, saturating at a limit
//  Revision : 1.0 - initial release
// ============================================================================
package freq_pkg;

    localparam int NUM_W         = 14;
    localparam int DEF_MAX_COUNT = 9999;

    typedef logic [NUM_W-1:0] num_t;

    // Add one bit to a count without ever exceeding lim.
    function automatic num_t sat_add_bit(input num_t a, input logic b, input num_t lim);
        num_t r;
        if (a >= lim) begin
            r = lim;
        end else begin
            r = a + num_t'(b);
        end
        return r;
    endfunction

endpackage : freq_pkg
`default_nettype wire

// File: rtl/sig_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sig_sync_edge
//  Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//             delay flop and a rising-edge detector.
//  Ports    : clk    in  1  system clock
//             rst    in  1  synchronous active-high reset
//             d      in  1  asynchronous input
//             edge_o out 1  one-cycle pulse per synchronized rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // Flops reset to 0, so an input already high at reset release counts once.
    assign edge_o = sync2_q & ~dly_q;

endmodule : sig_sync_edge
`default_nettype wire

// File: rtl/freq_gate_counter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_gate_counter
//  Purpose  : Counts rising edges of an asynchronous input over a fixed gate
//             window and publishes the clamped result once per window to the
//             4-digit display's num bus, with an overflow flag.
//  Params   : GATE_CYCLES - window length in clk cycles (>= 2)
//             MAX_COUNT   - largest displayable value (< 2^14 - 1)
//  Ports    : clk    in  1   system clock
//             rst    in  1   synchronous active-high reset
//             sig_in in  1   asynchronous pulse input
//             hold   in  1   (FREQ_HOLD_EN only) freeze published outputs
//             num    out 14  count of the last published window
//             valid  out 1   one-cycle strobe when num updates
//             ovf    out 1   last published window exceeded MAX_COUNT
//  Config   : FREQ_HOLD_EN - adds the hold input
//  Revision : 1.0 - initial release
// ============================================================================
module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int MAX_COUNT   = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
`ifdef FREQ_HOLD_EN
    input  logic             hold,
`endif
    output logic [NUM_W-1:0] num,
    output logic             valid,
    output logic             ovf
);

    localparam int            GW    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
    localparam num_t          MAXV  = num_t'(MAX_COUNT);
    localparam num_t          SAT   = num_t'(MAX_COUNT + 1);

    logic          w_edge;
    logic          w_gate_end;
    logic          w_publish;
    num_t          w_total;

    logic [GW-1:0] gcnt_q, gcnt_d;
    num_t          ecnt_q, ecnt_d;
    num_t          num_q,  num_d;
    logic          valid_q, valid_d;
    logic          ovf_q,   ovf_d;

    sig_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .edge_o (w_edge)
    );

    assign w_gate_end = (gcnt_q == GLAST);
    // An edge landing in the terminal cycle belongs to the closing window.
    assign w_total    = sat_add_bit(ecnt_q, w_edge, SAT);

`ifdef FREQ_HOLD_EN
    assign w_publish  = w_gate_end & ~hold;
`else
    assign w_publish  = w_gate_end;
`endif

    always_comb begin
        gcnt_d  = w_gate_end ? '0 : gcnt_q + GW'(1);
        // The window restarts its edge count even when publishing is held off.
        ecnt_d  = w_gate_end ? '0 : w_total;
        num_d   = num_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (w_publish) begin
            num_d   = (w_total > MAXV) ? MAXV : w_total;
            ovf_d   = (w_total > MAXV);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q  <= '0;
            ecnt_q  <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            ecnt_q  <= ecnt_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign num   = num_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule : freq_gate_counter
`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_gate_counter
//  Purpose  : Directed self-checking bench for freq_gate_counter. Instance A
//             uses a 100-cycle window; instance B uses a 2000-cycle window
//             with MAX_COUNT=999 to reach the clamp and overflow boundary.
//  Config   : FREQ_HOLD_EN - also exercises the hold input on instance A
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_gate_counter;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b0;
    logic [13:0] num_a, num_b;
    logic        valid_a, valid_b, ovf_a, ovf_b;
`ifdef FREQ_HOLD_EN
    logic        hold_a = 1'b0;
    logic        hold_b = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int per_a = 0, ph_a = 0;
    int per_b = 0, ph_b = 0;

    always #5 clk = ~clk;

    freq_gate_counter #(.GATE_CYCLES(100)) u_a (
        .clk    (clk),
        .rst    (rst_a),
        .sig_in (sig_a),
`ifdef FREQ_HOLD_EN
        .hold   (hold_a),
`endif
        .num    (num_a),
        .valid  (valid_a),
        .ovf    (ovf_a)
    );

    freq_gate_counter #(.GATE_CYCLES(2000), .MAX_COUNT(999)) u_b (
        .clk    (clk),
        .rst    (rst_b),
        .sig_in (sig_b),
`ifdef FREQ_HOLD_EN
        .hold   (hold_b),
`endif
        .num    (num_b),
        .valid  (valid_b),
        .ovf    (ovf_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample/drive 1 time unit after the rising edge. A nonzero
    // period drives a square wave (high for the first half of each period).
    task automatic step();
        @(posedge clk);
        #1;
        if (per_a != 0) begin
            sig_a = (ph_a < per_a / 2);
            ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        end
        if (per_b != 0) begin
            sig_b = (ph_b < per_b / 2);
            ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        end
    endtask

    task automatic wait_valid(input bit sel, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((sel ? valid_b : valid_a) !== 1'b1) && (n < 5000));
    endtask

    initial begin
        int n;
        int nv;

        // Reset state
        repeat (3) step();
        chk("rst_num", num_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_num_b", num_b, 0);

        // Quiet input: first valid exactly one window after release
        rst_a = 1'b0;
        wait_valid(1'b0, n);
        chk("first_valid_lat", n, 100);
        chk("quiet_num", num_a, 0);
        chk("quiet_ovf", ovf_a, 0);
        step();
        chk("valid_1cyc", valid_a, 0);
        wait_valid(1'b0, n);
        chk("quiet_period", n, 99);
        chk("quiet_num2", num_a, 0);

        // Single edge landing in the terminal cycle of the window
        repeat (97) step();
        sig_a = 1'b1;
        wait_valid(1'b0, n);
        chk("term_lat", n, 3);
        chk("term_num_closing", num_a, 1);
        wait_valid(1'b0, n);
        chk("term_period", n, 100);
        chk("term_num_next", num_a, 0);

        // Period-10 square wave -> 10 per window
        per_a = 10;
        ph_a  = 0;
        wait_valid(1'b0, n);
        wait_valid(1'b0, n);
        chk("p10_period", n, 100);
        chk("p10_num", num_a, 10);
        chk("p10_ovf", ovf_a, 0);
        step();
        chk("p10_valid_1cyc", valid_a, 0);

        // Reset mid-window for 3 cycles
        repeat (30) step();
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_num", num_a, 0);
            chk("midrst_valid", valid_a, 0);
            chk("midrst_ovf", ovf_a, 0);
        end
        rst_a = 1'b0;
        repeat (50) step();
        chk("postrst_num", num_a, 0);
        wait_valid(1'b0, n);
        chk("postrst_lat", n, 50);
        wait_valid(1'b0, n);
        chk("postrst_period", n, 100);
        chk("postrst_num10", num_a, 10);

`ifdef FREQ_HOLD_EN
        // Hold across two windows while switching to period 20
        hold_a = 1'b1;
        per_a  = 20;
        ph_a   = 0;
        nv     = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (valid_a === 1'b1) nv++;
        end
        chk("hold_no_valid", nv, 0);
        chk("hold_num", num_a, 10);
        chk("hold_ovf", ovf_a, 0);
        hold_a = 1'b0;
        wait_valid(1'b0, n);
        chk("hold_rel_lat", n, 100);
        chk("hold_rel_num", num_a, 5);
`else
        nv = 0;
`endif

        // Instance B: edge every 2 cycles, MAX_COUNT=999
        rst_b = 1'b0;
        per_b = 2;
        sig_b = 1'b1;
        ph_b  = 1;
        wait_valid(1'b1, n);
        chk("b_first_lat", n, 2000);
        chk("b_at_max_num", num_b, 999);
        chk("b_at_max_ovf", ovf_b, 0);
        wait_valid(1'b1, n);
        chk("b_sat_period", n, 2000);
        chk("b_sat_num", num_b, 999);
        chk("b_sat_ovf", ovf_b, 1);

        // Drop to period 4 -> 500 per window
        per_b = 4;
        ph_b  = 0;
        wait_valid(1'b1, n);
        wait_valid(1'b1, n);
        chk("b_p4_num", num_b, 500);
        chk("b_p4_ovf", ovf_b, 0);
        step();
        chk("b_valid_1cyc", valid_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_freq_gate_counter
`default_nettype wire
